tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Multi-channel programmable clock-enable generator for the display and GPU logic.
- One shared prescaler divides inputclock into a base tick. NUM_CH independent channel counters divide the base tick further, each producing a one-cycle enable pulse and a 50% duty square level.
- A valid/ready config port lets the host reprogram any channel at runtime. Period changes on a running channel take effect only at that channel's period boundary, so the output is glitch-free.

Parameters:
- NUM_CH, 4, number of output channels.
- CNT_W, 26, width of each channel period and counter.
- PRESCALE, 50, inputclock cycles per base tick; must be 2 or more.
- PRE_W, 16, prescaler counter width; must hold PRESCALE-1.

Ports:
- inputclock  in  1  system clock.
- clock_reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request can be accepted.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_period  in  CNT_W  base ticks per output tick; 0 means disable.
- tick_out  out  NUM_CH  one-cycle enable pulse per channel.
- level_out  out  NUM_CH  square wave; toggles on each tick of the channel.
- ch_active  out  NUM_CH  channel currently enabled.

Behaviour:
- Reset: one clock, asynchronous active-low reset. While clock_reset_n is low, all state clears:
  - prescaler and all channel counters = 0.
  - all periods = 0, all pending flags = 0.
  - tick_out, level_out, ch_active = 0.
- Reset may assert mid-operation; outputs clear immediately and any pending update is discarded.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - base_tick is an internal single-cycle strobe, high while the prescaler = PRESCALE-1.
  - The prescaler runs continuously, whether or not any channel is active.
- Channel state: per channel, cnt[CNT_W], period[CNT_W], pend_period[CNT_W], pend flag, active flag.
- Counting, when active and base_tick:
  - If cnt == period-1: on the next inputclock edge, tick_out[i] is 1 for exactly one cycle, level_out[i] toggles and cnt = 0. If pend is set, period = pend_period and pend clears.
  - Otherwise cnt increments.
- Resulting period: one tick_out pulse every period*PRESCALE inputclock cycles. Period 1 gives a pulse on every base tick.
- Config handshake:
  - cfg_ready = ~pend[cfg_ch]. It is combinational on cfg_ch and never depends on cfg_valid.
  - A transfer occurs when cfg_valid && cfg_ready. cfg_* are sampled at that edge.
- Config accepted with cfg_period == 0: next cycle active = 0, cnt = 0, level_out[i] = 0, period = 0. No further ticks.
- Config accepted with nonzero period on an inactive channel: applied next cycle; active = 1, period = cfg_period, cnt = 0, level = 0. The first tick comes after period full base ticks.
- Config accepted with nonzero period on an active channel: pend_period = cfg_period, pend = 1. cfg_ready for that channel drops until the next terminal tick applies the value.
- Simultaneous events:
  - Accept and terminal tick on the same channel in the same cycle: the terminal tick uses the old period (pend was 0). The new value goes pending and applies at the following terminal tick.
  - Accept of period 0 on an active channel in the same cycle as its terminal tick: the disable wins. tick_out for that cycle is suppressed and level clears.
  - A second accept to a channel with pend = 1 is impossible because cfg_ready = 0.
- Reprogramming one channel never perturbs the counters or outputs of other channels.
- Widths: cnt compares against period-1 in CNT_W bits. period is never 0 while active, so there is no underflow.

Decomposition:
- Shared package/header holds:
  - CH_W = $clog2(NUM_CH).
  - localparam PERIOD_DISABLE = 0.
  - a cfg request struct {ch, period}.
- Natural sub-module: tick_channel, one per channel, instantiated NUM_CH times. Inputs: base_tick, load, load_period. Outputs: tick, level, active, pend.
- The top level keeps the prescaler, cfg_ready muxing and address decode.

Test Plan:
- Reset, no config, PRESCALE=4 -> tick_out, level_out and ch_active stay 0 for 1000 cycles; cfg_ready = 1 for every cfg_ch.
- Program ch0 period=3, PRESCALE=4 -> ch_active[0]=1 next cycle. tick_out[0] pulses every 12 cycles, one cycle wide. level_out[0] toggles at each pulse, giving a 24-cycle square wave.
- ch0 running period=3; write period=5 mid-period -> cfg_ready(ch0)=0 until the next pulse. That interval stays 12 cycles, later intervals are 20 cycles, and there are no short or merged pulses.
- Write aligned to the terminal tick of ch1 (period 2 -> 4) -> the coincident pulse is on the old schedule. Exactly one more 8-cycle interval follows, then 16-cycle intervals.
- Program ch0=1, ch1=2, ch2=7, ch3=0, then disable ch2 mid-count -> each channel keeps its own rate. tick_out[2] and level_out[2] go to 0 next cycle; ch3 is never active.
- Deassert clock_reset_n asynchronously while ch0 has a pending update -> all outputs 0 without a clock edge. After release ch0 is inactive and cfg_ready(ch0)=1.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tick_scheduler_pkg
// Shared types and constants for the multi-channel clock-enable generator.
//   TS_NUM_CH / TS_CNT_W : default channel count and period/counter width
//   CH_W                 : channel-select width for the default channel count
//   PERIOD_DISABLE       : period value that switches a channel off
//   cfg_req_t            : one config request {ch, period}
// -----------------------------------------------------------------------------
package tick_scheduler_pkg;

  localparam int TS_NUM_CH = 4;
  localparam int TS_CNT_W  = 26;
  localparam int CH_W      = $clog2(TS_NUM_CH);

  localparam int PERIOD_DISABLE = 0;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [TS_CNT_W-1:0] period;
  } cfg_req_t;

endpackage : tick_scheduler_pkg

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One output channel: divides the shared base tick by a programmable period,
// emitting a one-cycle pulse and toggling a square level at every terminal
// count. A period written while the channel runs is parked until the next
// terminal count so that no short or merged interval is ever produced.
//   clk, rst_n   : clock, asynchronous active-low reset
//   base_tick    : single-cycle strobe from the shared prescaler
//   load         : accepted config request for this channel
//   load_period  : period carried by that request (0 disables)
//   tick         : registered one-cycle enable pulse
//   level        : registered square wave, toggles on each tick
//   active       : channel currently enabled
//   pend         : a new period is waiting for the next terminal count
// -----------------------------------------------------------------------------
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int CNT_W = TS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             base_tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  output logic             tick,
  output logic             level,
  output logic             active,
  output logic             pend
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_OFF  = CNT_W'(PERIOD_DISABLE);

  logic [CNT_W-1:0] cnt_r,         cnt_n;
  logic [CNT_W-1:0] period_r,      period_n;
  logic [CNT_W-1:0] pend_period_r, pend_period_n;
  logic             pend_r,        pend_n;
  logic             active_r,      active_n;
  logic             tick_r,        tick_n;
  logic             level_r,       level_n;
  logic             terminal_s;
  logic             disable_s;

  // period_r is never 0 while active_r is set, so period_r-1 cannot wrap
  // in a way that matters; the subtraction is gated by active_r.
  assign terminal_s = active_r && base_tick && (cnt_r == (period_r - CNT_ONE));
  assign disable_s  = load && (load_period == PER_OFF);

  // Next-state: disable has priority, then first load, then counting with a
  // possible parked period update.
  always_comb begin
    cnt_n         = cnt_r;
    period_n      = period_r;
    pend_period_n = pend_period_r;
    pend_n        = pend_r;
    active_n      = active_r;
    tick_n        = 1'b0;
    level_n       = level_r;

    if (disable_s) begin
      // Wins over a coincident terminal count: the pulse is suppressed.
      active_n = 1'b0;
      cnt_n    = CNT_ZERO;
      period_n = CNT_ZERO;
      pend_n   = 1'b0;
      level_n  = 1'b0;
    end else if (load && !active_r) begin
      active_n = 1'b1;
      period_n = load_period;
      cnt_n    = CNT_ZERO;
      pend_n   = 1'b0;
      level_n  = 1'b0;
    end else begin
      if (terminal_s) begin
        tick_n  = 1'b1;
        level_n = ~level_r;
        cnt_n   = CNT_ZERO;
        if (pend_r) begin
          period_n = pend_period_r;
          pend_n   = 1'b0;
        end else begin
          period_n = period_r;
        end
      end else if (active_r && base_tick) begin
        cnt_n = cnt_r + CNT_ONE;
      end else begin
        cnt_n = cnt_r;
      end
      // A load here targets a running channel. It is only accepted while
      // pend_r is clear, so a coincident terminal count above used the old
      // period and this value waits for the following one.
      if (load) begin
        pend_period_n = load_period;
        pend_n        = 1'b1;
      end else begin
        pend_period_n = pend_period_r;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= CNT_ZERO;
      period_r      <= CNT_ZERO;
      pend_period_r <= CNT_ZERO;
      pend_r        <= 1'b0;
      active_r      <= 1'b0;
      tick_r        <= 1'b0;
      level_r       <= 1'b0;
    end else begin
      cnt_r         <= cnt_n;
      period_r      <= period_n;
      pend_period_r <= pend_period_n;
      pend_r        <= pend_n;
      active_r      <= active_n;
      tick_r        <= tick_n;
      level_r       <= level_n;
    end
  end

  assign tick   = tick_r;
  assign level  = level_r;
  assign active = active_r;
  assign pend   = pend_r;

endmodule : tick_channel

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// Multi-channel programmable clock-enable generator. A shared prescaler turns
// inputclock into a base tick; NUM_CH tick_channel instances divide it further.
// A valid/ready port reprograms channels at runtime without glitches.
//   inputclock    : system clock
//   clock_reset_n : asynchronous active-low reset
//   cfg_valid     : config request valid
//   cfg_ready     : request for cfg_ch can be accepted (combinational on cfg_ch)
//   cfg_ch        : target channel
//   cfg_period    : base ticks per output tick, 0 disables the channel
//   tick_out      : one-cycle enable pulse per channel
//   level_out     : square wave per channel, toggles on every tick
//   ch_active     : channel currently enabled
// -----------------------------------------------------------------------------
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NUM_CH   = TS_NUM_CH,
  parameter int CNT_W    = TS_CNT_W,
  parameter int PRESCALE = 50,
  parameter int PRE_W    = 16
) (
  input  logic                      inputclock,
  input  logic                      clock_reset_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic [NUM_CH-1:0]         tick_out,
  output logic [NUM_CH-1:0]         level_out,
  output logic [NUM_CH-1:0]         ch_active
);

  localparam int               CHW      = $clog2(NUM_CH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

  logic [PRE_W-1:0]  pre_r;
  logic              base_tick_s;
  cfg_req_t          req_s;
  logic              ready_s;
  logic              accept_s;
  logic [NUM_CH-1:0] load_s;
  logic [NUM_CH-1:0] pend_s;

  assign req_s.ch     = cfg_ch;
  assign req_s.period = cfg_period;

  // Shared prescaler: free-running 0..PRESCALE-1, independent of channel state.
  always_ff @(posedge inputclock or negedge clock_reset_n) begin
    if (!clock_reset_n) begin
      pre_r <= PRE_ZERO;
    end else if (base_tick_s) begin
      pre_r <= PRE_ZERO;
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  assign base_tick_s = (pre_r == PRE_LAST);

  // cfg_ready mux: a channel with a parked period refuses new requests.
  // Channel numbers beyond NUM_CH are accepted and dropped.
  if (NUM_CH == (1 << CHW)) begin : g_ready_full
    assign ready_s = ~pend_s[req_s.ch];
  end else begin : g_ready_part
    // Range-checked select for non-power-of-two channel counts.
    always_comb begin
      ready_s = 1'b1;
      if (int'(req_s.ch) < NUM_CH) begin
        ready_s = ~pend_s[req_s.ch];
      end else begin
        ready_s = 1'b1;
      end
    end
  end

  assign cfg_ready = ready_s;
  assign accept_s  = cfg_valid && ready_s;

  // Address decode and one channel instance per output.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load_s[g] = accept_s && (req_s.ch == CHW'(g));

    tick_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (inputclock),
      .rst_n       (clock_reset_n),
      .base_tick   (base_tick_s),
      .load        (load_s[g]),
      .load_period (req_s.period),
      .tick        (tick_out[g]),
      .level       (level_out[g]),
      .active      (ch_active[g]),
      .pend        (pend_s[g])
    );
  end

endmodule : tick_scheduler

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler (PRESCALE=4). Stimulus pushes the
// expected pulse times/levels per channel; a negedge monitor pops and checks
// every pulse the DUT presents. cyc counts posedges since reset release, so
// base ticks land on edges 4, 8, 12, ... and a pulse from edge k is seen at cyc=k.
module tb_tick_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 26;
  localparam int PS  = 4;

  typedef struct {
    int   t;
    logic lvl;
  } pulse_t;

  logic            inputclock    = 1'b0;
  logic            clock_reset_n = 1'b0;
  logic            cfg_valid     = 1'b0;
  logic            cfg_ready;
  logic [1:0]      cfg_ch        = 2'd0;
  logic [CW-1:0]   cfg_period    = '0;
  logic [NCH-1:0]  tick_out;
  logic [NCH-1:0]  level_out;
  logic [NCH-1:0]  ch_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  pulse_t exp_q[NCH][$];

  tick_scheduler #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .PRESCALE (PS),
    .PRE_W    (16)
  ) dut (
    .inputclock    (inputclock),
    .clock_reset_n (clock_reset_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_period    (cfg_period),
    .tick_out      (tick_out),
    .level_out     (level_out),
    .ch_active     (ch_active)
  );

  always #5 inputclock = ~inputclock;

  always @(posedge inputclock or negedge clock_reset_n) begin
    if (!clock_reset_n) cyc <= 0;
    else                cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of that channel's queue.
  always @(negedge inputclock) begin
    pulse_t p;
    if (clock_reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (tick_out[c]) begin
          if (exp_q[c].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse ch%0d: got pulse at cyc %0d, expected none", c, cyc);
          end else begin
            p = exp_q[c].pop_front();
            chk($sformatf("pulse_time_ch%0d", c), cyc, p.t);
            chk($sformatf("pulse_level_ch%0d", c), {31'd0, level_out[c]}, {31'd0, p.lvl});
          end
        end
      end
    end
  end

  task automatic push_one(input int ch, input int t, input logic lvl);
    pulse_t p;
    p.t   = t;
    p.lvl = lvl;
    exp_q[ch].push_back(p);
  endtask

  // Regular train from a fresh channel: level starts at 1 on the first pulse.
  task automatic push_train(input int ch, input int first, input int step, input int last_excl);
    logic lvl;
    lvl = 1'b1;
    for (int t = first; t < last_excl; t += step) begin
      push_one(ch, t, lvl);
      lvl = ~lvl;
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge inputclock); while (cyc < n);
  endtask

  // Issue a request so that it is accepted at posedge number e.
  task automatic cfg_at(input int ch, input int per, input int e);
    while (cyc < e - 1) @(negedge inputclock);
    cfg_ch     = ch[1:0];
    cfg_period = per[CW-1:0];
    cfg_valid  = 1'b1;
    #1;
    chk($sformatf("cfg_ready_at_issue_ch%0d", ch), {31'd0, cfg_ready}, 32'd1);
    @(posedge inputclock);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tick"},   {28'd0, tick_out},  32'd0);
    chk({tag, "_level"},  {28'd0, level_out}, 32'd0);
    chk({tag, "_active"}, {28'd0, ch_active}, 32'd0);
  endtask

  task automatic do_reset();
    repeat (30) @(negedge inputclock);
    for (int c = 0; c < NCH; c++) chk($sformatf("drained_ch%0d", c), exp_q[c].size(), 32'd0);
    #2;
    cfg_valid     = 1'b0;
    clock_reset_n = 1'b0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(negedge inputclock);
    clock_reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] acc;
    logic           ch3_seen;

    // 1: reset, idle for 1000 cycles, cfg_ready high everywhere.
    #3;
    chk_outputs_zero("por");
    repeat (2) @(negedge inputclock);
    clock_reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge inputclock);
      acc = acc | tick_out | level_out | ch_active;
    end
    chk("idle_outputs", {28'd0, acc}, 32'd0);
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = c[1:0];
      #1;
      chk($sformatf("idle_ready_ch%0d", c), {31'd0, cfg_ready}, 32'd1);
    end

    // 2: ch0 period 3 -> pulses every 12 cycles, 24-cycle square.
    do_reset();
    push_train(0, 12, 12, 50);
    cfg_at(0, 3, 2);
    chk("s2_active", {28'd0, ch_active}, 32'h1);
    cfg_at(0, 0, 50);
    chk("s2_off_active", {28'd0, ch_active}, 32'h0);
    chk("s2_off_level", {28'd0, level_out}, 32'h0);

    // 3: ch0 3 -> 5 mid-period; 12-cycle interval, then 20.
    do_reset();
    push_one(0, 12, 1'b1);
    push_one(0, 24, 1'b0);
    push_one(0, 44, 1'b1);
    push_one(0, 64, 1'b0);
    push_one(0, 84, 1'b1);
    cfg_at(0, 3, 2);
    wait_cyc(14);
    cfg_ch = 2'd0;
    #1;
    chk("s3_ready_before", {31'd0, cfg_ready}, 32'd1);
    cfg_at(0, 5, 16);
    chk("s3_ready_pend", {31'd0, cfg_ready}, 32'd0);
    wait_cyc(23);
    chk("s3_ready_still_pend", {31'd0, cfg_ready}, 32'd0);
    wait_cyc(24);
    chk("s3_ready_applied", {31'd0, cfg_ready}, 32'd1);
    wait_cyc(89);
    chk("s3_level_before_off", {31'd0, level_out[0]}, 32'd1);
    cfg_at(0, 0, 90);
    chk("s3_level_off", {31'd0, level_out[0]}, 32'd0);

    // 4: ch1 2 -> 4 written on its terminal tick.
    do_reset();
    push_one(1, 8, 1'b1);
    push_one(1, 16, 1'b0);
    push_one(1, 24, 1'b1);
    push_one(1, 40, 1'b0);
    push_one(1, 56, 1'b1);
    push_one(1, 72, 1'b0);
    cfg_at(1, 2, 2);
    cfg_at(1, 4, 16);
    chk("s4_ready_pend", {31'd0, cfg_ready}, 32'd0);
    wait_cyc(23);
    chk("s4_ready_still_pend", {31'd0, cfg_ready}, 32'd0);
    wait_cyc(24);
    chk("s4_ready_applied", {31'd0, cfg_ready}, 32'd1);
    cfg_at(1, 0, 75);

    // 5: four channels at independent rates, ch2 disabled mid-count,
    //    ch1 disabled exactly on its terminal tick.
    do_reset();
    push_train(0, 4, 4, 121);
    push_train(1, 8, 8, 120);
    push_one(2, 32, 1'b1);
    push_one(2, 60, 1'b0);
    push_one(2, 88, 1'b1);
    cfg_at(0, 1, 2);
    cfg_at(1, 2, 3);
    cfg_at(2, 7, 5);
    cfg_at(3, 0, 6);
    ch3_seen = 1'b0;
    for (int c = 7; c <= 88; c++) begin
      wait_cyc(c);
      ch3_seen = ch3_seen | ch_active[3];
    end
    chk("s5_ch3_never_active", {31'd0, ch3_seen}, 32'd0);
    chk("s5_active_all", {28'd0, ch_active}, 32'h7);
    chk("s5_ch2_level_before_off", {31'd0, level_out[2]}, 32'd1);
    cfg_at(2, 0, 90);
    chk("s5_ch2_tick_off", {31'd0, tick_out[2]}, 32'd0);
    chk("s5_ch2_level_off", {31'd0, level_out[2]}, 32'd0);
    chk("s5_active_after_ch2_off", {28'd0, ch_active}, 32'h3);
    cfg_at(1, 0, 120);
    chk("s5_ch1_disable_wins", {31'd0, tick_out[1]}, 32'd0);
    chk("s5_active_after_ch1_off", {28'd0, ch_active}, 32'h1);
    cfg_at(0, 0, 121);
    chk("s5_active_none", {28'd0, ch_active}, 32'h0);

    // 6: async reset while ch0 has a parked period.
    do_reset();
    push_one(0, 12, 1'b1);
    cfg_at(0, 3, 2);
    cfg_at(0, 5, 14);
    wait_cyc(18);
    cfg_ch = 2'd0;
    #1;
    chk("s6_ready_pend", {31'd0, cfg_ready}, 32'd0);
    chk("s6_active", {31'd0, ch_active[0]}, 32'd1);
    chk("s6_level", {31'd0, level_out[0]}, 32'd1);
    #2;
    clock_reset_n = 1'b0;
    #1;
    chk_outputs_zero("s6_async");
    repeat (2) @(negedge inputclock);
    clock_reset_n = 1'b1;
    #1;
    chk("s6_post_active", {28'd0, ch_active}, 32'h0);
    chk("s6_post_ready", {31'd0, cfg_ready}, 32'd1);
    repeat (60) @(negedge inputclock);
    for (int c = 0; c < NCH; c++) chk($sformatf("final_drained_ch%0d", c), exp_q[c].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tick_scheduler
